// File: rtl/lane_arbiter.sv
// lane_arbiter: two-lane merge point. Each lane feeds its own small FIFO;
// a round-robin arbiter drains one word per clk_2f edge into a registered
// output, and each lane gets an almost-full pause and a sticky overflow flag.
module lane_arbiter #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              grant,
  output logic              pause0,
  output logic              pause1,
  output logic              err0,
  output logic              err1
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

  // Lane-indexed views of the input ports so both FIFOs come from one generate loop
  logic [1:0]        valid_in_vec;
  logic [DATA_W-1:0] data_in_arr [2];
  logic [DATA_W-1:0] head_data   [2];
  logic [1:0]        not_empty;
  logic [1:0]        pop_vec;
  logic [1:0]        pause_vec;
  logic [1:0]        err_vec;

  logic              do_pop;
  logic              serve_lane;

  logic [DATA_W-1:0] data_out_reg;
  logic              valid_out_reg;
  logic              grant_reg;
  logic              last_grant_reg;

  assign valid_in_vec   = {valid_in1, valid_in0};
  assign data_in_arr[0] = data_in0;
  assign data_in_arr[1] = data_in1;

  // Arbiter works on pre-edge occupancy: alternate under contention, else take whoever has data
  always_comb begin
    do_pop     = |not_empty;
    serve_lane = 1'b0;
    if (not_empty[0] && not_empty[1]) begin
      serve_lane = ~last_grant_reg;
    end else if (not_empty[1]) begin
      serve_lane = 1'b1;
    end
    pop_vec = 2'b00;
    if (do_pop) begin
      pop_vec = serve_lane ? 2'b10 : 2'b01;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [DATA_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [CNT_W-1:0]  count_reg;
      logic [CNT_W-1:0]  count_next;
      logic              full;
      logic              push;
      logic              overflow;
      logic              pause_reg;
      logic              err_reg;

      // A full FIFO refuses the word even if it is being popped this edge
      assign full     = (count_reg == FULL_CNT);
      assign push     = valid_in_vec[gi] && !full;
      assign overflow = valid_in_vec[gi] && full;

      assign not_empty[gi] = (count_reg != '0);
      assign head_data[gi] = mem[rd_ptr_reg];
      assign pause_vec[gi] = pause_reg;
      assign err_vec[gi]   = err_reg;

      // Occupancy after this edge; push and pop together leave it unchanged
      always_comb begin
        count_next = count_reg;
        case ({push, pop_vec[gi]})
          2'b10:   count_next = count_reg + CNT_W'(1);
          2'b01:   count_next = count_reg - CNT_W'(1);
          default: count_next = count_reg;
        endcase
      end

      // Storage write; reset wins so nothing is written while it is held
      always_ff @(posedge clk_2f) begin
        if (reset && push) begin
          mem[wr_ptr_reg] <= data_in_arr[gi];
        end
      end

      // Pointers, occupancy, almost-full pause and sticky overflow flag
      always_ff @(posedge clk_2f) begin
        if (!reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          pause_reg  <= 1'b0;
          err_reg    <= 1'b0;
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          end
          if (pop_vec[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          end
          count_reg <= count_next;
          pause_reg <= (count_next >= AF_CNT);
          if (overflow) begin
            err_reg <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Output register: the served FIFO head lands here on the same edge it is popped
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      data_out_reg   <= '0;
      valid_out_reg  <= 1'b0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (do_pop) begin
      data_out_reg   <= head_data[serve_lane];
      valid_out_reg  <= 1'b1;
      grant_reg      <= serve_lane;
      last_grant_reg <= serve_lane;
    end else begin
      valid_out_reg  <= 1'b0;
    end
  end

  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;
  assign grant     = grant_reg;
  assign pause0    = pause_vec[0];
  assign pause1    = pause_vec[1];
  assign err0      = err_vec[0];
  assign err1      = err_vec[1];

endmodule
